// File: rtl/controle_nivel_valvula.sv
// Inlet-valve level controller: hysteresis filling, critical-level alarm and a
// filling-timeout fault, driven by strobed packed-BCD distance samples.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// REPOUSO  | valve closed, waiting for confirmed low level
// ENCHENDO | valve open, filling; watching for progress
// CRITICO  | water at/above critical mark, valve forced closed, alarm on
// MANUAL   | valve follows abrir_valv
// FALHA    | filling made no progress, valve closed until limpar_falha
module controle_nivel_valvula #(
  parameter int CONFIRM = 3,
  parameter int TIMEOUT = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] medida,
  input  logic        medida_pronta,
  input  logic [11:0] nv_crit,
  input  logic [11:0] nv_alto,
  input  logic [11:0] nv_baixo,
  input  logic        manual,
  input  logic        abrir_valv,
  input  logic        limpar_falha,
  output logic        valvula,
  output logic        alarme_critico,
  output logic        falha,
  output logic        erro_medida,
  output logic [2:0]  db_estado
);

  typedef enum logic [2:0] {
    REPOUSO  = 3'b000,
    ENCHENDO = 3'b001,
    CRITICO  = 3'b010,
    MANUAL   = 3'b011,
    FALHA    = 3'b100
  } estado_t;

  localparam logic [3:0] CONF_MAX = 4'(CONFIRM);
  localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);

  estado_t     estado, estado_nxt;
  logic [3:0]  conf_cnt, conf_nxt;
  logic [7:0]  tmo_cnt, tmo_nxt;
  logic [11:0] ultima, ult_nxt;

  logic bcd_ok, amostra, le_crit, le_alto, ge_baixo, gt_alto;

  assign bcd_ok   = (medida[11:8] <= 4'd9) && (medida[7:4] <= 4'd9) && (medida[3:0] <= 4'd9);
  assign amostra  = medida_pronta && bcd_ok;
  // Valid packed BCD orders the same as plain binary, so compare directly.
  assign le_crit  = amostra && (medida <= nv_crit);
  assign le_alto  = medida <= nv_alto;
  assign gt_alto  = medida > nv_alto;
  assign ge_baixo = medida >= nv_baixo;

  always_comb begin
    estado_nxt = estado;
    conf_nxt   = conf_cnt;
    tmo_nxt    = tmo_cnt;
    ult_nxt    = ultima;
    case (estado)
      REPOUSO: begin
        if (le_crit) estado_nxt = CRITICO;
        else if (manual) estado_nxt = MANUAL;
        else if (amostra) begin
          if (ge_baixo) begin
            if (conf_cnt + 4'd1 >= CONF_MAX) begin
              estado_nxt = ENCHENDO;
              ult_nxt    = medida;
            end else begin
              conf_nxt = conf_cnt + 4'd1;
            end
          end else begin
            conf_nxt = 4'd0;
          end
        end
      end
      ENCHENDO: begin
        if (le_crit) estado_nxt = CRITICO;
        else if (manual) estado_nxt = MANUAL;
        else if (amostra && le_alto) estado_nxt = REPOUSO;
        else if (amostra) begin
          if (medida < ultima) begin
            ult_nxt = medida;
            tmo_nxt = 8'd0;
          end else if (tmo_cnt + 8'd1 >= TMO_MAX) begin
            estado_nxt = FALHA;
          end else begin
            tmo_nxt = tmo_cnt + 8'd1;
          end
        end
      end
      CRITICO: begin
        if (amostra && gt_alto) estado_nxt = manual ? MANUAL : REPOUSO;
      end
      MANUAL: begin
        if (le_crit) estado_nxt = CRITICO;
        else if (!manual) estado_nxt = REPOUSO;
      end
      FALHA: begin
        if (limpar_falha) estado_nxt = REPOUSO;
      end
      default: estado_nxt = REPOUSO;
    endcase
    if (estado_nxt != estado) begin
      conf_nxt = 4'd0;
      tmo_nxt  = 8'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado         <= REPOUSO;
      conf_cnt       <= 4'd0;
      tmo_cnt        <= 8'd0;
      ultima         <= 12'h999;
      valvula        <= 1'b0;
      alarme_critico <= 1'b0;
      falha          <= 1'b0;
      erro_medida    <= 1'b0;
    end else begin
      estado         <= estado_nxt;
      conf_cnt       <= conf_nxt;
      tmo_cnt        <= tmo_nxt;
      ultima         <= ult_nxt;
      valvula        <= (estado_nxt == ENCHENDO) || ((estado_nxt == MANUAL) && abrir_valv);
      alarme_critico <= estado_nxt == CRITICO;
      falha          <= estado_nxt == FALHA;
      erro_medida    <= medida_pronta && !bcd_ok;
    end
  end

  assign db_estado = estado;

endmodule
